// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width; a 1-bit counter still suffices for WIDTH == 2
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Single combinational full-adder cell, reused for every bit position.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    fa_bit u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_c)
    );

    // acc only needs WIDTH-1 bits: the final cell output supplies the MSB directly
    assign acc_shift = {fa_s, acc};
    assign last_bit  = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Carry register during the last RUN cycle is the carry into the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_shift[WIDTH-1:1];
                    carry <= fa_c;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    if (last_bit) begin
                        sum  <= acc_shift;
                        cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        ovf  <= carry ^ fa_c;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in on a start strobe, then sequences a single 1-bit full-adder cell over WIDTH clock cycles, LSB first. Carry is held in a flip-flop between bits. The final sum and carry-out are registered for downstream use, such as the 7-segment display path. Ripple width is traded for latency and reuses one full-adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; WIDTH >= 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; accepted only in IDLE
- a  in  WIDTH  operand A; sampled on accepted start
- b  in  WIDTH  operand B; sampled on accepted start
- cin  in  1  carry-in; sampled on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high in DONE
- sum  out  WIDTH  registered result; holds until the next result is written
- cout  out  1  registered carry-out; holds with sum
- ovf  out  1  signed overflow; present only when SERIAL_ADD_OVF_EN is defined

## Operation
- FSM states are IDLE, RUN and DONE; reset state is IDLE.
- IDLE:
  - On start=1, load a_sh<=a, b_sh<=b, carry<=cin, bit counter<=0, acc<=0, then go to RUN.
  - With start=0, stay in IDLE.
- RUN, each cycle:
  - Full-adder cell inputs are a_sh[0], b_sh[0] and carry.
  - Cell sum bit shifts into acc at the MSB, acc shifting right.
  - carry<=cell cout.
  - a_sh and b_sh shift right by 1.
  - Counter increments.
  - On the cycle where counter==WIDTH-1, write sum<={cell s, acc[WIDTH-1:1]} and cout<=cell cout, then go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing, no error flag.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as bit WIDTH, so {cout,sum} == a+b+cin exactly.
- sum/cout change only on the RUN→DONE transition and on reset.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and counter are all 0.
- Reset mid-operation aborts immediately: the partial result is discarded and outputs return to their reset values.

## Timing
- start=1 sampled in IDLE at edge T.
- busy=1 for edges T+1 … T+WIDTH, which is WIDTH cycles.
- done=1 and the new sum/cout are visible after edge T+WIDTH+1.
- IDLE is re-entered after edge T+WIDTH+2, so the next start can be accepted there.
- Throughput is one operation per WIDTH+2 cycles when start is held high continuously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - An ovf output port is added.
  - A flop records the carry into the MSB, which is the carry register value during the final RUN cycle.
  - ovf <= carry_into_msb ^ final cout, written together with sum.
  - ovf resets to 0.
- SERIAL_ADD_OVF_EN undefined: the ovf port and its flop do not exist. All other behaviour is identical.

## Structure
- Package serial_add_pkg holds:
  - state enum state_t {IDLE, RUN, DONE}, 2 bits
  - default WIDTH constant
  - helper for counter width
- Sub-module fa_bit: a purely combinational 1-bit full adder.
  - s = a^b^cin
  - cout = ab | cin(a^b)
  - Instantiated once inside serial_adder_ctrl.

## Test plan
- **Reset:** assert rst mid-cycle with no clock → busy=0, done=0, sum=0x00, cout=0, ovf=0 immediately.
- **Basic add:** WIDTH=8, a=0x3C, b=0x55, cin=0 → busy for 8 cycles, then done pulse at T+9 with sum=0x91, cout=0, ovf=1.
- **Full carry chain:**
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1.
- **Start during RUN:** start a=0x01, b=0x02, then assert start with a=0x7F at T+3 → ignored; result sum=0x03. sum stays 0x03 until the next accepted start completes.
- **Reset mid-operation:** start a=0x3C, b=0x55, assert rst at T+4 → outputs return to reset values at once, no done pulse. A new start after rst release yields the correct sum.
- **Back-to-back:** hold start=1 with random operands for 200 operations → one accept every 10 cycles. Each {cout,sum} matches a+b+cin, checked against a reference model.
